// File: rtl/reservation_station_if.sv
// rtl/reservation_station_if.sv - dispatch, CDB snoop and ALU issue signal bundle
interface reservation_station_if #(
    parameter int ADDR_WIDTH   = 32,
    parameter int RoB_WIDTH    = 4,
    parameter int EX_RoB_WIDTH = 5
);
    logic                    DPRS_en;
    logic [ADDR_WIDTH-1:0]   DPRS_pc;
    logic [6:0]              DPRS_opcode;
    logic [EX_RoB_WIDTH-1:0] DPRS_Qj;
    logic [EX_RoB_WIDTH-1:0] DPRS_Qk;
    logic [31:0]             DPRS_Vj;
    logic [31:0]             DPRS_Vk;
    logic [31:0]             DPRS_imm;
    logic [RoB_WIDTH-1:0]    DPRS_RoB_index;
    logic                    RSDP_full;

    logic                    CDBRS_RS_en;
    logic [RoB_WIDTH-1:0]    CDBRS_RS_RoB_index;
    logic [31:0]             CDBRS_RS_value;
    logic                    CDBRS_LSB_en;
    logic [RoB_WIDTH-1:0]    CDBRS_LSB_RoB_index;
    logic [31:0]             CDBRS_LSB_value;

    logic                    RSALU_en;
    logic [6:0]              RSALU_opcode;
    logic [ADDR_WIDTH-1:0]   RSALU_pc;
    logic [31:0]             RSALU_Vj;
    logic [31:0]             RSALU_Vk;
    logic [31:0]             RSALU_imm;
    logic [RoB_WIDTH-1:0]    RSALU_RoB_index;

    modport slave (
        input  DPRS_en, DPRS_pc, DPRS_opcode, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_imm,
               DPRS_RoB_index,
        input  CDBRS_RS_en, CDBRS_RS_RoB_index, CDBRS_RS_value,
               CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value,
        output RSDP_full,
        output RSALU_en, RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm, RSALU_RoB_index
    );

    modport master (
        output DPRS_en, DPRS_pc, DPRS_opcode, DPRS_Qj, DPRS_Qk, DPRS_Vj, DPRS_Vk, DPRS_imm,
               DPRS_RoB_index,
        output CDBRS_RS_en, CDBRS_RS_RoB_index, CDBRS_RS_value,
               CDBRS_LSB_en, CDBRS_LSB_RoB_index, CDBRS_LSB_value,
        input  RSDP_full,
        input  RSALU_en, RSALU_opcode, RSALU_pc, RSALU_Vj, RSALU_Vk, RSALU_imm, RSALU_RoB_index
    );
endinterface

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - 8-entry ALU reservation station with dual-CDB operand wakeup
module reservation_station #(
    parameter int ADDR_WIDTH   = 32,
    parameter int RoB_WIDTH    = 4,
    parameter int EX_RoB_WIDTH = 5,
    parameter int NON_DEP      = 16,
    parameter int RS_WIDTH     = 3
) (
    input  logic Sys_clk,
    input  logic Sys_rst_n,
    input  logic Sys_rdy,
    input  logic RoBRS_pre_judge,
    reservation_station_if.slave bus
);
    localparam int RS_SIZE = 1 << RS_WIDTH;
    localparam int CW      = RS_WIDTH + 1;
    localparam logic [EX_RoB_WIDTH-1:0] NON_DEP_TAG = EX_RoB_WIDTH'(NON_DEP);

    typedef struct packed {
        logic                    busy;
        logic [ADDR_WIDTH-1:0]   pc;
        logic [6:0]              opcode;
        logic [EX_RoB_WIDTH-1:0] qj;
        logic [EX_RoB_WIDTH-1:0] qk;
        logic [31:0]             vj;
        logic [31:0]             vk;
        logic [31:0]             imm;
        logic [RoB_WIDTH-1:0]    rob;
    } entry_t;

    entry_t ent_q [RS_SIZE];
    entry_t ent_d [RS_SIZE];

    logic [CW-1:0]         free_cnt;
    logic                  alloc_ok, issue_ok;
    logic [RS_WIDTH-1:0]   alloc_idx, issue_idx;

    logic                  alu_en_q;
    logic [6:0]            alu_opcode_q;
    logic [ADDR_WIDTH-1:0] alu_pc_q;
    logic [31:0]           alu_vj_q, alu_vk_q, alu_imm_q;
    logic [RoB_WIDTH-1:0]  alu_rob_q;

    // The extra tag bit set means "ready", so such a tag can never equal a broadcast index.
    function automatic logic tag_hit(input logic [EX_RoB_WIDTH-1:0] tag, input logic en,
                                     input logic [RoB_WIDTH-1:0] idx);
        return en && (tag == {1'b0, idx});
    endfunction

    always_comb begin
        free_cnt  = '0;
        alloc_ok  = 1'b0;
        alloc_idx = '0;
        issue_ok  = 1'b0;
        issue_idx = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!ent_q[i].busy) begin
                free_cnt  = free_cnt + CW'(1);
                alloc_ok  = 1'b1;
                alloc_idx = RS_WIDTH'(i);
            end else if (ent_q[i].qj == NON_DEP_TAG && ent_q[i].qk == NON_DEP_TAG) begin
                issue_ok  = 1'b1;
                issue_idx = RS_WIDTH'(i);
            end
        end
    end

    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (ent_q[i].busy) begin
                if (tag_hit(ent_q[i].qj, bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index)) begin
                    ent_d[i].qj = NON_DEP_TAG;
                    ent_d[i].vj = bus.CDBRS_RS_value;
                end else if (tag_hit(ent_q[i].qj, bus.CDBRS_LSB_en, bus.CDBRS_LSB_RoB_index)) begin
                    ent_d[i].qj = NON_DEP_TAG;
                    ent_d[i].vj = bus.CDBRS_LSB_value;
                end
                if (tag_hit(ent_q[i].qk, bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index)) begin
                    ent_d[i].qk = NON_DEP_TAG;
                    ent_d[i].vk = bus.CDBRS_RS_value;
                end else if (tag_hit(ent_q[i].qk, bus.CDBRS_LSB_en, bus.CDBRS_LSB_RoB_index)) begin
                    ent_d[i].qk = NON_DEP_TAG;
                    ent_d[i].vk = bus.CDBRS_LSB_value;
                end
            end
        end
        if (issue_ok) ent_d[issue_idx].busy = 1'b0;
        // Issue and allocation never target the same slot: allocation only picks pre-edge free entries.
        if (bus.DPRS_en && alloc_ok) begin
            ent_d[alloc_idx].busy   = 1'b1;
            ent_d[alloc_idx].pc     = bus.DPRS_pc;
            ent_d[alloc_idx].opcode = bus.DPRS_opcode;
            ent_d[alloc_idx].imm    = bus.DPRS_imm;
            ent_d[alloc_idx].rob    = bus.DPRS_RoB_index;
            ent_d[alloc_idx].qj     = bus.DPRS_Qj;
            ent_d[alloc_idx].vj     = bus.DPRS_Vj;
            ent_d[alloc_idx].qk     = bus.DPRS_Qk;
            ent_d[alloc_idx].vk     = bus.DPRS_Vk;
            if (tag_hit(bus.DPRS_Qj, bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index)) begin
                ent_d[alloc_idx].qj = NON_DEP_TAG;
                ent_d[alloc_idx].vj = bus.CDBRS_RS_value;
            end else if (tag_hit(bus.DPRS_Qj, bus.CDBRS_LSB_en, bus.CDBRS_LSB_RoB_index)) begin
                ent_d[alloc_idx].qj = NON_DEP_TAG;
                ent_d[alloc_idx].vj = bus.CDBRS_LSB_value;
            end
            if (tag_hit(bus.DPRS_Qk, bus.CDBRS_RS_en, bus.CDBRS_RS_RoB_index)) begin
                ent_d[alloc_idx].qk = NON_DEP_TAG;
                ent_d[alloc_idx].vk = bus.CDBRS_RS_value;
            end else if (tag_hit(bus.DPRS_Qk, bus.CDBRS_LSB_en, bus.CDBRS_LSB_RoB_index)) begin
                ent_d[alloc_idx].qk = NON_DEP_TAG;
                ent_d[alloc_idx].vk = bus.CDBRS_LSB_value;
            end
        end
    end

    always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
        if (!Sys_rst_n) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= '0;
            alu_en_q     <= 1'b0;
            alu_opcode_q <= '0;
            alu_pc_q     <= '0;
            alu_vj_q     <= '0;
            alu_vk_q     <= '0;
            alu_imm_q    <= '0;
            alu_rob_q    <= '0;
        end else if (!RoBRS_pre_judge) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i].busy <= 1'b0;
            alu_en_q <= 1'b0;
        end else if (Sys_rdy) begin
            for (int i = 0; i < RS_SIZE; i++) ent_q[i] <= ent_d[i];
            alu_en_q <= issue_ok;
            if (issue_ok) begin
                alu_opcode_q <= ent_q[issue_idx].opcode;
                alu_pc_q     <= ent_q[issue_idx].pc;
                alu_vj_q     <= ent_q[issue_idx].vj;
                alu_vk_q     <= ent_q[issue_idx].vk;
                alu_imm_q    <= ent_q[issue_idx].imm;
                alu_rob_q    <= ent_q[issue_idx].rob;
            end
        end
    end

    // The extra free==1 term covers the dispatch already in flight from the dispatcher.
    assign bus.RSDP_full       = (free_cnt == '0) | ((free_cnt == CW'(1)) & bus.DPRS_en);
    assign bus.RSALU_en        = alu_en_q;
    assign bus.RSALU_opcode    = alu_opcode_q;
    assign bus.RSALU_pc        = alu_pc_q;
    assign bus.RSALU_Vj        = alu_vj_q;
    assign bus.RSALU_Vk        = alu_vk_q;
    assign bus.RSALU_imm       = alu_imm_q;
    assign bus.RSALU_RoB_index = alu_rob_q;

    always_ff @(posedge Sys_clk) begin
        if (Sys_rst_n && RoBRS_pre_judge && Sys_rdy && bus.DPRS_en) assert (free_cnt != '0);
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed self-checking bench for reservation_station
module tb_reservation_station;
    localparam logic [4:0] ND = 5'd16;

    logic clk = 1'b0;
    logic rst_n, rdy, pre_judge;
    int   checks = 0;
    int   passed = 0;

    reservation_station_if rif ();

    reservation_station dut (
        .Sys_clk        (clk),
        .Sys_rst_n      (rst_n),
        .Sys_rdy        (rdy),
        .RoBRS_pre_judge(pre_judge),
        .bus            (rif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic disp(input logic [6:0] op, input logic [31:0] pc, input logic [4:0] qj,
                        input logic [31:0] vj, input logic [4:0] qk, input logic [31:0] vk,
                        input logic [31:0] imm, input logic [3:0] rob);
        rif.DPRS_en        = 1'b1;
        rif.DPRS_opcode    = op;
        rif.DPRS_pc        = pc;
        rif.DPRS_Qj        = qj;
        rif.DPRS_Vj        = vj;
        rif.DPRS_Qk        = qk;
        rif.DPRS_Vk        = vk;
        rif.DPRS_imm       = imm;
        rif.DPRS_RoB_index = rob;
    endtask

    task automatic cdb_idle();
        rif.CDBRS_RS_en  = 1'b0;
        rif.CDBRS_LSB_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1; pre_judge = 1'b1;
        disp(7'd0, 32'd0, ND, 32'd0, ND, 32'd0, 32'd0, 4'd0);
        rif.DPRS_en = 1'b0;
        rif.CDBRS_RS_en = 1'b0;  rif.CDBRS_RS_RoB_index = '0;  rif.CDBRS_RS_value = '0;
        rif.CDBRS_LSB_en = 1'b0; rif.CDBRS_LSB_RoB_index = '0; rif.CDBRS_LSB_value = '0;

        step();
        chk("reset_en", 32'(rif.RSALU_en), 32'd0);
        chk("reset_vj", rif.RSALU_Vj, 32'd0);
        chk("reset_rob", 32'(rif.RSALU_RoB_index), 32'd0);
        chk("reset_full", 32'(rif.RSDP_full), 32'd0);
        rst_n = 1'b1;
        step();

        // T1: ready addi issues one edge after allocation, for exactly one cycle
        disp(7'd12, 32'h1000, ND, 32'd5, ND, 32'd0, 32'd3, 4'd2);
        step();
        rif.DPRS_en = 1'b0;
        chk("t1_no_issue_at_alloc", 32'(rif.RSALU_en), 32'd0);
        step();
        chk("t1_en", 32'(rif.RSALU_en), 32'd1);
        chk("t1_vj", rif.RSALU_Vj, 32'd5);
        chk("t1_imm", rif.RSALU_imm, 32'd3);
        chk("t1_rob", 32'(rif.RSALU_RoB_index), 32'd2);
        chk("t1_pc", rif.RSALU_pc, 32'h1000);
        chk("t1_op", 32'(rif.RSALU_opcode), 32'd12);
        step();
        chk("t1_pulse_end", 32'(rif.RSALU_en), 32'd0);

        // T2: operand woken by the LSB bus two cycles after dispatch
        disp(7'd26, 32'h2000, 5'd4, 32'd0, ND, 32'd9, 32'd0, 4'd3);
        step();
        rif.DPRS_en = 1'b0;
        step();
        chk("t2_waiting", 32'(rif.RSALU_en), 32'd0);
        rif.CDBRS_LSB_en = 1'b1; rif.CDBRS_LSB_RoB_index = 4'd4; rif.CDBRS_LSB_value = 32'h77;
        step();
        cdb_idle();
        chk("t2_no_issue_at_wake", 32'(rif.RSALU_en), 32'd0);
        step();
        chk("t2_en", 32'(rif.RSALU_en), 32'd1);
        chk("t2_vj", rif.RSALU_Vj, 32'h77);
        chk("t2_vk", rif.RSALU_Vk, 32'd9);
        chk("t2_rob", 32'(rif.RSALU_RoB_index), 32'd3);

        // T3: tags resolved by same-cycle broadcasts on both buses at allocation
        disp(7'd26, 32'h3000, 5'd6, 32'd0, 5'd7, 32'd0, 32'd0, 4'd8);
        rif.CDBRS_RS_en = 1'b1;  rif.CDBRS_RS_RoB_index = 4'd6;  rif.CDBRS_RS_value = 32'h10;
        rif.CDBRS_LSB_en = 1'b1; rif.CDBRS_LSB_RoB_index = 4'd7; rif.CDBRS_LSB_value = 32'h22;
        step();
        rif.DPRS_en = 1'b0;
        cdb_idle();
        step();
        chk("t3_en", 32'(rif.RSALU_en), 32'd1);
        chk("t3_vj", rif.RSALU_Vj, 32'h10);
        chk("t3_vk", rif.RSALU_Vk, 32'h22);
        step();

        // T4: fill all eight entries, check full, then drain in index order
        for (int i = 0; i < 8; i++) begin
            disp(7'd20, 32'h4000 + 32'(i), 5'd9, 32'd0, ND, 32'd1, 32'(i), 4'(i));
            #1;
            if (i == 6) chk("t4_full_at_6busy", 32'(rif.RSDP_full), 32'd0);
            if (i == 7) chk("t4_full_at_7busy_en", 32'(rif.RSDP_full), 32'd1);
            step();
        end
        rif.DPRS_en = 1'b0;
        #1;
        chk("t4_full_at_8busy", 32'(rif.RSDP_full), 32'd1);
        rif.CDBRS_RS_en = 1'b1; rif.CDBRS_RS_RoB_index = 4'd9; rif.CDBRS_RS_value = 32'hAB;
        step();
        cdb_idle();
        chk("t4_no_issue_at_wake", 32'(rif.RSALU_en), 32'd0);
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("t4_en_%0d", k), 32'(rif.RSALU_en), 32'd1);
            chk($sformatf("t4_rob_%0d", k), 32'(rif.RSALU_RoB_index), 32'(k));
            chk($sformatf("t4_vj_%0d", k), rif.RSALU_Vj, 32'hAB);
        end
        step();
        chk("t4_drained_en", 32'(rif.RSALU_en), 32'd0);
        chk("t4_drained_full", 32'(rif.RSDP_full), 32'd0);

        // T5: flush with one entry about to issue and a dispatch presented on the flush edge
        for (int i = 0; i < 3; i++) begin
            disp(7'd20, 32'h5000, 5'd12, 32'd0, ND, 32'd0, 32'd0, 4'(i));
            step();
        end
        disp(7'd20, 32'h5100, ND, 32'd1, ND, 32'd2, 32'd0, 4'd3);
        step();
        disp(7'd20, 32'h5200, ND, 32'd1, ND, 32'd2, 32'd0, 4'd4);
        pre_judge = 1'b0;
        step();
        pre_judge = 1'b1;
        rif.DPRS_en = 1'b0;
        chk("t5_flush_en", 32'(rif.RSALU_en), 32'd0);
        chk("t5_flush_full", 32'(rif.RSDP_full), 32'd0);
        rif.CDBRS_RS_en = 1'b1; rif.CDBRS_RS_RoB_index = 4'd12; rif.CDBRS_RS_value = 32'h1;
        step();
        cdb_idle();
        chk("t5_after1", 32'(rif.RSALU_en), 32'd0);
        step();
        chk("t5_after2", 32'(rif.RSALU_en), 32'd0);

        // T6a: freeze for three cycles with a ready entry
        disp(7'd15, 32'h6000, ND, 32'h33, ND, 32'd0, 32'd0, 4'd5);
        step();
        rif.DPRS_en = 1'b0;
        rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("t6_frozen_%0d", c), 32'(rif.RSALU_en), 32'd0);
        end
        rdy = 1'b1;
        step();
        chk("t6_thaw_en", 32'(rif.RSALU_en), 32'd1);
        chk("t6_thaw_vj", rif.RSALU_Vj, 32'h33);
        chk("t6_thaw_rob", 32'(rif.RSALU_RoB_index), 32'd5);

        // T6b: asynchronous reset between edges while an issue is on the outputs
        disp(7'd15, 32'h7000, 5'd13, 32'd0, ND, 32'd0, 32'd0, 4'd6);
        step();
        disp(7'd15, 32'h7100, ND, 32'h44, ND, 32'd0, 32'd0, 4'd7);
        step();
        rif.DPRS_en = 1'b0;
        step();
        chk("t6_pre_reset_en", 32'(rif.RSALU_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_async_en", 32'(rif.RSALU_en), 32'd0);
        chk("t6_async_vj", rif.RSALU_Vj, 32'd0);
        #1;
        rst_n = 1'b1;
        rif.CDBRS_LSB_en = 1'b1; rif.CDBRS_LSB_RoB_index = 4'd13; rif.CDBRS_LSB_value = 32'h5;
        step();
        cdb_idle();
        chk("t6_post_reset1", 32'(rif.RSALU_en), 32'd0);
        step();
        chk("t6_post_reset2", 32'(rif.RSALU_en), 32'd0);
        chk("t6_post_reset_full", 32'(rif.RSDP_full), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
